boreal_bus_master_bridge: RTL

//  Upstream of the bus interconnect's public master port. Converts a valid/ready command stream (CPU/DMA) into single

---
 rtl/boreal_bus_master_bridge_pkg.sv | 19 +
 rtl/boreal_bus_master_bridge_watchdog.sv | 31 +++
 rtl/boreal_bus_master_bridge.sv | 132 +++++++++++++
 3 files changed

// File: rtl/boreal_bus_master_bridge_pkg.sv
// rtl/boreal_bus_master_bridge_pkg.sv - shared types and constants for the bus master bridge
package boreal_bus_master_bridge_pkg;

  typedef enum logic [1:0] {
    BRG_IDLE = 2'd0,
    BRG_BUS  = 2'd1,
    BRG_RSP  = 2'd2
  } brg_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BUS     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ALIGN   = 2'd3
  } err_cause_t;

  localparam int BRG_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/boreal_bus_master_bridge_watchdog.sv
// rtl/boreal_bus_master_bridge_watchdog.sv - request-high cycle watchdog with expire pulse
module boreal_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] count;

  // Count enabled cycles since the last clear; the count holds the number of
  // completed cycles, so the final allowed cycle is the one where count==LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (TIMEOUT_CYCLES != 0) && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = enable && (TIMEOUT_CYCLES != 0) && (count == LAST);

endmodule

// File: rtl/boreal_bus_master_bridge.sv
// rtl/boreal_bus_master_bridge.sv - valid/ready command stream to single-outstanding req/ack bus bridge
module boreal_bus_master_bridge
  import boreal_bus_master_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = BRG_DEFAULT_TIMEOUT,
  parameter int ALIGN_CHECK    = 1,
  parameter int TO_CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [31:0]         cmd_addr,
  input  logic [31:0]         cmd_wdata,
  input  logic [3:0]          cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [31:0]         bus_addr,
  output logic [31:0]         bus_wdata,
  output logic [3:0]          bus_strb,
  input  logic [31:0]         bus_rdata,
  input  logic                bus_ack,
  input  logic                bus_err,
  output logic [TO_CNT_W-1:0] timeout_count,
  output logic                busy
);

  brg_state_t state, next_state;
  err_cause_t rsp_cause;
  logic       accept, misalign, take_ack, expire_hit;
  logic       wd_expire;

  boreal_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (state == BRG_BUS),
    .expire (wd_expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BRG_IDLE;
    else     state <= next_state;
  end

  // Next-state and per-cycle control decode; ack takes priority over expiry.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    misalign   = 1'b0;
    take_ack   = 1'b0;
    expire_hit = 1'b0;
    case (state)
      BRG_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if ((ALIGN_CHECK != 0) && (cmd_addr[1:0] != 2'b00)) begin
            misalign   = 1'b1;
            next_state = BRG_RSP;
          end else begin
            next_state = BRG_BUS;
          end
        end
      end
      BRG_BUS: begin
        if (bus_ack) begin
          take_ack   = 1'b1;
          next_state = BRG_RSP;
        end else if (wd_expire) begin
          expire_hit = 1'b1;
          next_state = BRG_RSP;
        end
      end
      BRG_RSP: begin
        if (rsp_ready) next_state = BRG_IDLE;
      end
      default: next_state = BRG_IDLE;
    endcase
  end

  // Command latch, bus request, response buffer and timeout status counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req       <= 1'b0;
      bus_wr        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_strb      <= '0;
      rsp_rdata     <= '0;
      rsp_cause     <= ERR_NONE;
      timeout_count <= '0;
    end else begin
      if (accept) begin
        bus_wr    <= cmd_wr;
        bus_addr  <= cmd_addr;
        bus_wdata <= cmd_wdata;
        bus_strb  <= cmd_strb;
        if (misalign) begin
          rsp_rdata <= '0;
          rsp_cause <= ERR_ALIGN;
        end else begin
          bus_req <= 1'b1;
        end
      end
      if (take_ack) begin
        bus_req   <= 1'b0;
        rsp_rdata <= (bus_wr || bus_err) ? 32'd0 : bus_rdata;
        rsp_cause <= bus_err ? ERR_BUS : ERR_NONE;
      end
      if (expire_hit) begin
        bus_req   <= 1'b0;
        rsp_rdata <= '0;
        rsp_cause <= ERR_TIMEOUT;
        if (timeout_count != '1) timeout_count <= timeout_count + TO_CNT_W'(1);
      end
    end
  end

  assign cmd_ready   = (state == BRG_IDLE);
  assign busy        = (state != BRG_IDLE);
  assign rsp_valid   = (state == BRG_RSP);
  assign rsp_err     = (rsp_cause != ERR_NONE);
  assign rsp_timeout = (rsp_cause == ERR_TIMEOUT);

endmodule
